// File: rtl/vector_line_engine.sv
// Bresenham vector line engine: accepts move/draw commands, keeps a cursor and emits
// every point of a draw with a settle hold, beam flag, frame clamping and pause.
module vector_line_engine #(
  parameter int unsigned OUT_WIDTH   = 8,
  parameter int unsigned FRAME_MIN   = 0,
  parameter int unsigned FRAME_MAX   = 255,
  parameter int unsigned HOLD_CYCLES = 1,
  parameter int unsigned MOVE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_draw,
  input  logic [OUT_WIDTH-1:0] cmd_x,
  input  logic [OUT_WIDTH-1:0] cmd_y,
  output logic [OUT_WIDTH-1:0] x_out,
  output logic [OUT_WIDTH-1:0] y_out,
  output logic                 beam_on,
  output logic                 busy,
  output logic                 done
);
  localparam int unsigned SW     = OUT_WIDTH + 2;
  localparam int unsigned CntMax = (HOLD_CYCLES > MOVE_CYCLES) ? HOLD_CYCLES : MOVE_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0]      HoldLast = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0]      MoveLoad = CntW'(MOVE_CYCLES);
  localparam logic [CntW-1:0]      MoveLast = CntW'(MOVE_CYCLES - 1);
  localparam logic [OUT_WIDTH-1:0] FMin     = OUT_WIDTH'(FRAME_MIN);
  localparam logic signed [SW-1:0] FMinS    = SW'(FRAME_MIN);
  localparam logic signed [SW-1:0] FMaxS    = SW'(FRAME_MAX);

  typedef enum logic [2:0] {StIdle, StSetup, StStep, StMove, StDone} state_e;

  state_e                 state_q, state_d;
  logic [OUT_WIDTH-1:0]   x_q, x_d, y_q, y_d;
  logic [OUT_WIDTH-1:0]   tx_q, tx_d, ty_q, ty_d;
  logic signed [SW-1:0]   dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic                   sx_q, sx_d, sy_q, sy_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   beam_q, beam_d, done_q, done_d;

  logic signed [SW-1:0]   ddx, ddy;
  logic signed [SW:0]     e2, dxe, dye;

  function automatic logic [OUT_WIDTH-1:0] clamp(input logic [OUT_WIDTH-1:0] v);
    logic signed [SW-1:0] vs;
    vs = $signed({2'b00, v});
    if (vs < FMinS) begin
      clamp = FMinS[OUT_WIDTH-1:0];
    end else if (vs > FMaxS) begin
      clamp = FMaxS[OUT_WIDTH-1:0];
    end else begin
      clamp = v;
    end
  endfunction

  always_comb begin
    ddx = $signed({2'b00, tx_q}) - $signed({2'b00, x_q});
    ddy = $signed({2'b00, ty_q}) - $signed({2'b00, y_q});
    e2  = {err_q, 1'b0};
    dxe = {dx_q[SW-1], dx_q};
    dye = {dy_q[SW-1], dy_q};
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    err_d   = err_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    cnt_d   = cnt_q;
    beam_d  = beam_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          tx_d = clamp(cmd_x);
          ty_d = clamp(cmd_y);
          if (cmd_draw) begin
            state_d = StSetup;
          end else begin
            state_d = StMove;
            cnt_d   = MoveLoad;
          end
        end
      end
      StSetup: begin
        if (enable) begin
          dx_d  = ddx[SW-1] ? -ddx : ddx;
          dy_d  = ddy[SW-1] ? ddy : -ddy;
          sx_d  = ddx[SW-1];
          sy_d  = ddy[SW-1];
          err_d = dx_d + dy_d;
          cnt_d = '0;
          state_d = (ddx == '0 && ddy == '0) ? StDone : StStep;
        end
      end
      StStep: begin
        if (enable) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
          end else if (x_q == tx_q && y_q == ty_q) begin
            // End point's hold has expired.
            state_d = StDone;
            beam_d  = 1'b0;
          end else begin
            beam_d = 1'b1;
            cnt_d  = HoldLast;
            if (e2 >= dye) begin
              err_d = err_d + dy_q;
              x_d   = sx_q ? x_q - OUT_WIDTH'(1) : x_q + OUT_WIDTH'(1);
            end
            if (e2 <= dxe) begin
              err_d = err_d + dx_q;
              y_d   = sy_q ? y_q - OUT_WIDTH'(1) : y_q + OUT_WIDTH'(1);
            end
          end
        end
      end
      StMove: begin
        if (enable) begin
          if (cnt_q == MoveLoad) begin
            x_d    = tx_q;
            y_d    = ty_q;
            beam_d = 1'b0;
            cnt_d  = MoveLast;
          end else if (cnt_q == '0) begin
            state_d = StDone;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
      end
      StDone: begin
        if (enable) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    done_d = (state_d == StDone);
    if (state_d == StDone) begin
      beam_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      x_q     <= FMin;
      y_q     <= FMin;
      tx_q    <= FMin;
      ty_q    <= FMin;
      dx_q    <= '0;
      dy_q    <= '0;
      err_q   <= '0;
      sx_q    <= 1'b0;
      sy_q    <= 1'b0;
      cnt_q   <= '0;
      beam_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      err_q   <= err_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      cnt_q   <= cnt_d;
      beam_q  <= beam_d;
      done_q  <= done_d;
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign x_out     = x_q;
  assign y_out     = y_q;
  assign beam_on   = beam_q;
  assign done      = done_q;

endmodule

// File: tb/tb_vector_line_engine.sv
// Scoreboard bench for vector_line_engine: three configurations, per-cycle expected
// output traces queued at command acceptance and compared on the falling edge.
module tb_vector_line_engine;
  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic       beam;
    logic       done;
    logic       busy;
    logic       ready;
  } samp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic       cmd_draw = 1'b0;
  logic [7:0] cmd_x = '0;
  logic [7:0] cmd_y = '0;
  logic       v_a = 1'b0, v_b = 1'b0, v_c = 1'b0;
  logic       r_a, r_b, r_c, b_a, b_b, b_c, bz_a, bz_b, bz_c, d_a, d_b, d_c;
  logic [7:0] x_a, y_a, x_b, y_b, x_c, y_c;

  samp_t exp_q[$];
  int    sel = 0;
  int    tests = 0;
  int    fails = 0;
  bit    hit;

  always #5 clk = ~clk;

  vector_line_engine u_a (
    .clk(clk), .rst(rst), .enable(enable), .cmd_valid(v_a), .cmd_ready(r_a),
    .cmd_draw(cmd_draw), .cmd_x(cmd_x), .cmd_y(cmd_y), .x_out(x_a), .y_out(y_a),
    .beam_on(b_a), .busy(bz_a), .done(d_a)
  );

  vector_line_engine #(.FRAME_MIN(16), .FRAME_MAX(240)) u_b (
    .clk(clk), .rst(rst), .enable(enable), .cmd_valid(v_b), .cmd_ready(r_b),
    .cmd_draw(cmd_draw), .cmd_x(cmd_x), .cmd_y(cmd_y), .x_out(x_b), .y_out(y_b),
    .beam_on(b_b), .busy(bz_b), .done(d_b)
  );

  vector_line_engine #(.HOLD_CYCLES(3)) u_c (
    .clk(clk), .rst(rst), .enable(enable), .cmd_valid(v_c), .cmd_ready(r_c),
    .cmd_draw(cmd_draw), .cmd_x(cmd_x), .cmd_y(cmd_y), .x_out(x_c), .y_out(y_c),
    .beam_on(b_c), .busy(bz_c), .done(d_c)
  );

  function automatic samp_t observe(input int d);
    case (d)
      0:       observe = '{x_a, y_a, b_a, d_a, bz_a, r_a};
      1:       observe = '{x_b, y_b, b_b, d_b, bz_b, r_b};
      default: observe = '{x_c, y_c, b_c, d_c, bz_c, r_c};
    endcase
  endfunction

  task automatic push(input int x, input int y, input logic beam, input logic dn,
                      input logic bz, input int n);
    samp_t s;
    s = '{x[7:0], y[7:0], beam, dn, bz, ~bz};
    for (int i = 0; i < n; i++) exp_q.push_back(s);
  endtask

  task automatic check(input string tag, input samp_t o, input samp_t e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s dut%0d: observed x=%0d y=%0d beam=%b done=%b busy=%b ready=%b, expected x=%0d y=%0d beam=%b done=%b busy=%b ready=%b",
             tag, sel, o.x, o.y, o.beam, o.done, o.busy, o.ready,
             e.x, e.y, e.beam, e.done, e.busy, e.ready);
    end
  endtask

  // Pops up to n expected samples, one per falling edge.
  task automatic drain(input string tag, input int n);
    for (int i = 0; i < n && exp_q.size() > 0; i++) begin
      @(negedge clk);
      check(tag, observe(sel), exp_q.pop_front());
    end
  endtask

  task automatic issue(input int d, input logic draw, input int x, input int y);
    @(negedge clk);
    sel      = d;
    cmd_draw = draw;
    cmd_x    = x[7:0];
    cmd_y    = y[7:0];
    v_a      = (d == 0);
    v_b      = (d == 1);
    v_c      = (d == 2);
    @(posedge clk);
    #1;
    v_a   = 1'b0;
    v_b   = 1'b0;
    v_c   = 1'b0;
    cmd_x = ~cmd_x;
    cmd_y = ~cmd_y;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    sel = 0; check("reset_a", observe(0), '{8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    sel = 1; check("reset_b", observe(1), '{8'd16, 8'd16, 1'b0, 1'b0, 1'b0, 1'b1});
    sel = 2; check("reset_c", observe(2), '{8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1});

    // Draw (0,0) -> (3,1), one cycle per point.
    issue(0, 1'b1, 3, 1);
    push(0, 0, 0, 0, 1, 2);
    push(1, 0, 1, 0, 1, 1);
    push(2, 1, 1, 0, 1, 1);
    push(3, 1, 1, 0, 1, 1);
    push(3, 1, 0, 1, 1, 1);
    push(3, 1, 0, 0, 0, 1);
    drain("draw_3_1", 100);

    // Blanked move, then a pure diagonal draw.
    issue(0, 1'b0, 200, 10);
    push(3, 1, 0, 0, 1, 1);
    push(200, 10, 0, 0, 1, 4);
    push(200, 10, 0, 1, 1, 1);
    push(200, 10, 0, 0, 0, 1);
    drain("move_200_10", 100);

    issue(0, 1'b1, 197, 13);
    push(200, 10, 0, 0, 1, 2);
    push(199, 11, 1, 0, 1, 1);
    push(198, 12, 1, 0, 1, 1);
    push(197, 13, 1, 0, 1, 1);
    push(197, 13, 0, 1, 1, 1);
    push(197, 13, 0, 0, 0, 1);
    drain("diag", 100);

    // Zero-length draw to the current cursor.
    issue(0, 1'b1, 197, 13);
    push(197, 13, 0, 0, 1, 1);
    push(197, 13, 0, 1, 1, 1);
    push(197, 13, 0, 0, 0, 1);
    drain("zero_len", 100);

    // Clamped target (255,0) -> (240,16): 224 horizontal points.
    issue(1, 1'b1, 255, 0);
    push(16, 16, 0, 0, 1, 2);
    for (int x = 17; x <= 240; x++) push(x, 16, 1, 0, 1, 1);
    push(240, 16, 0, 1, 1, 1);
    push(240, 16, 0, 0, 0, 1);
    drain("clamp", 1000);

    // HOLD_CYCLES=3 with enable low for edges E3..E7.
    issue(2, 1'b1, 0, 2);
    push(0, 0, 0, 0, 1, 2);
    push(0, 1, 1, 0, 1, 8);
    push(0, 2, 1, 0, 1, 3);
    push(0, 2, 0, 1, 1, 1);
    push(0, 2, 0, 0, 0, 1);
    drain("pause", 3);
    enable = 1'b0;
    drain("pause", 5);
    enable = 1'b1;
    drain("pause", 100);

    // 100-point line (197,13) -> (97,13), reset asynchronously during point 50.
    issue(0, 1'b1, 97, 13);
    sel = 0;
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk);
      hit = (x_a == 8'd147);
    end
    tests++;
    assert (hit) else begin
      fails++;
      $error("FAIL reach_point50: observed x=%0d, expected x=147 within 300 cycles", x_a);
    end
    #1;
    rst = 1'b1;
    #1;
    check("rst_async", observe(0), '{8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_hold", observe(0), '{8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_release", observe(0), '{8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
